ascon_arbiter: RTL and testbench

- Shares one ascon encryption engine between NUM_REQ requesters on a job basis.
- Round-robin picks a requester, latches its key and nonce, and pulses the engine start.
- Streams the owner's data to the engine and routes cipher blocks and the final tag back to that owner only.
- A watchdog recovers the engine if done never arrives; the arbiter sits between the client interfaces and the ascon top.

---
 rtl/ascon_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_ascon_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_arbiter.sv
// ascon_arbiter: shares one ascon engine between NUM_REQ clients, one job at a time.
// A job is granted round-robin, runs until the engine reports done, and is then
// handed back. A watchdog flushes the engine if done never arrives.
module ascon_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_sys_enable,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*128-1:0]   i_key,
    input  logic [NUM_REQ*128-1:0]   i_nonce,
    input  logic [NUM_REQ*64-1:0]    i_data,
    input  logic [NUM_REQ-1:0]       i_data_valid,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic [63:0]              o_cipher,
    output logic [NUM_REQ-1:0]       o_valid_cipher,
    output logic [127:0]             o_tag,
    output logic [NUM_REQ-1:0]       o_done,
    output logic [NUM_REQ-1:0]       o_timeout,
    output logic                     o_busy,
    output logic                     o_eng_reset_n,
    output logic                     o_eng_start,
    output logic                     o_eng_data_valid,
    output logic [63:0]              o_eng_data,
    output logic [127:0]             o_eng_key,
    output logic [127:0]             o_eng_nonce,
    input  logic [63:0]              i_eng_cipher,
    input  logic                     i_eng_valid_cipher,
    input  logic [127:0]             i_eng_tag,
    input  logic                     i_eng_done
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DONE,
        ST_FLUSH
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [127:0]         tag_q, tag_d;
    logic [127:0]         key_q, key_d;
    logic [127:0]         nonce_q, nonce_d;

    logic                 pick_found;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W-1:0]     cand_idx;
    int                   cand;
    logic [127:0]         pick_key;
    logic [127:0]         pick_nonce;
    logic [63:0]          owner_data;
    logic                 owner_valid;
    logic [PTR_W-1:0]     owner_next;

    // Round-robin search: first pending request at or above the pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand     = (int'(ptr_q) + i) % NUM_REQ;
            cand_idx = PTR_W'(cand);
            if (!pick_found && i_req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Select the key and nonce of the requester about to be granted.
    always_comb begin
        pick_key   = '0;
        pick_nonce = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (pick_idx == PTR_W'(r)) begin
                pick_key   = i_key[128*r +: 128];
                pick_nonce = i_nonce[128*r +: 128];
            end
        end
    end

    // Route the current owner's data stream towards the engine.
    always_comb begin
        owner_data  = '0;
        owner_valid = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_q[r]) begin
                owner_data  = i_data[64*r +: 64];
                owner_valid = i_data_valid[r];
            end
        end
    end

    assign owner_next = (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;

    // Job sequencing; nothing advances while the system enable is low.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        wd_d    = wd_q;
        tag_d   = tag_q;
        key_d   = key_q;
        nonce_d = nonce_q;
        if (i_sys_enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_d           = '0;
                        grant_d[pick_idx] = 1'b1;
                        owner_d           = pick_idx;
                        key_d             = pick_key;
                        nonce_d           = pick_nonce;
                        state_d           = ST_START;
                    end
                end
                ST_START: begin
                    wd_d    = '0;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (i_eng_done) begin
                        tag_d   = i_eng_tag;
                        state_d = ST_DONE;
                    end else if (wd_q == WD_LAST) begin
                        state_d = ST_FLUSH;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
                ST_DONE, ST_FLUSH: begin
                    grant_d = '0;
                    ptr_d   = owner_next;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            wd_q    <= '0;
            tag_q   <= '0;
            key_q   <= '0;
            nonce_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            wd_q    <= wd_d;
            tag_q   <= tag_d;
            key_q   <= key_d;
            nonce_q <= nonce_d;
        end
    end

    assign o_grant          = grant_q;
    assign o_cipher         = i_eng_cipher;
    assign o_valid_cipher   = (state_q == ST_RUN && i_eng_valid_cipher) ? grant_q : '0;
    assign o_tag            = tag_q;
    assign o_done           = (state_q == ST_DONE) ? grant_q : '0;
    assign o_timeout        = (state_q == ST_FLUSH) ? grant_q : '0;
    assign o_busy           = (state_q != ST_IDLE);
    assign o_eng_reset_n    = ~reset & (state_q != ST_FLUSH);
    assign o_eng_start      = (state_q == ST_START);
    assign o_eng_data_valid = (state_q == ST_RUN) & owner_valid;
    assign o_eng_data       = owner_data;
    assign o_eng_key        = key_q;
    assign o_eng_nonce      = nonce_q;

endmodule

// File: tb/tb_ascon_arbiter.sv
// tb_ascon_arbiter: directed and randomized jobs against a round-robin job model.
module tb_ascon_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;
    localparam logic [127:0] K0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] N0 = 128'h101112131415161718191A1B1C1D1E1F;

    logic               clock = 1'b0;
    logic               reset;
    logic               i_sys_enable;
    logic [N-1:0]       i_req;
    logic [N*128-1:0]   i_key;
    logic [N*128-1:0]   i_nonce;
    logic [N*64-1:0]    i_data;
    logic [N-1:0]       i_data_valid;
    logic [N-1:0]       o_grant;
    logic [63:0]        o_cipher;
    logic [N-1:0]       o_valid_cipher;
    logic [127:0]       o_tag;
    logic [N-1:0]       o_done;
    logic [N-1:0]       o_timeout;
    logic               o_busy;
    logic               o_eng_reset_n;
    logic               o_eng_start;
    logic               o_eng_data_valid;
    logic [63:0]        o_eng_data;
    logic [127:0]       o_eng_key;
    logic [127:0]       o_eng_nonce;
    logic [63:0]        i_eng_cipher;
    logic               i_eng_valid_cipher;
    logic [127:0]       i_eng_tag;
    logic               i_eng_done;

    int                 checks = 0;
    int                 errors = 0;
    int                 exp_ptr;
    logic [127:0]       exp_tag;

    ascon_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clock              (clock),
        .reset              (reset),
        .i_sys_enable       (i_sys_enable),
        .i_req              (i_req),
        .i_key              (i_key),
        .i_nonce            (i_nonce),
        .i_data             (i_data),
        .i_data_valid       (i_data_valid),
        .o_grant            (o_grant),
        .o_cipher           (o_cipher),
        .o_valid_cipher     (o_valid_cipher),
        .o_tag              (o_tag),
        .o_done             (o_done),
        .o_timeout          (o_timeout),
        .o_busy             (o_busy),
        .o_eng_reset_n      (o_eng_reset_n),
        .o_eng_start        (o_eng_start),
        .o_eng_data_valid   (o_eng_data_valid),
        .o_eng_data         (o_eng_data),
        .o_eng_key          (o_eng_key),
        .o_eng_nonce        (o_eng_nonce),
        .i_eng_cipher       (i_eng_cipher),
        .i_eng_valid_cipher (i_eng_valid_cipher),
        .i_eng_tag          (i_eng_tag),
        .i_eng_done         (i_eng_done)
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Round-robin rule: first set request at or after the pointer, wrapping.
    function automatic int modelPick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Fresh random client data and engine outputs; optional fixed routing pattern.
    task automatic applyStimulus(input bit fixed_pattern);
        for (int r = 0; r < N; r++) i_data[64*r +: 64] = {$urandom, $urandom};
        i_data_valid       = N'($urandom);
        i_eng_cipher       = {$urandom, $urandom};
        i_eng_valid_cipher = 1'($urandom_range(0, 1));
        i_eng_tag          = rand128();
        if (fixed_pattern) begin
            i_data[63:0]    = 64'hAAAA_AAAA_AAAA_AAAA;
            i_data[127:64]  = 64'h5555_5555_5555_5555;
            i_data_valid[0] = 1'b1;
        end
        #1;
    endtask

    // One full job: done_at is the RUN cycle index where the engine reports done
    // (>= TO means never), stall_at the RUN cycle before which enable drops for 5 cycles.
    task automatic runJob(input logic [N-1:0] req, input int done_at, input int stall_at,
                          input bit fixed_pattern, input bit drop_req, input bit fixed_keys);
        int           g;
        logic [N-1:0] gmask;
        logic [127:0] exp_key;
        logic [127:0] exp_nonce;
        logic [63:0]  exp_data;
        for (int r = 0; r < N; r++) begin
            i_key[128*r +: 128]   = rand128();
            i_nonce[128*r +: 128] = rand128();
        end
        if (fixed_keys) begin
            i_key[127:0]   = K0;
            i_nonce[127:0] = N0;
        end
        i_req     = req;
        g         = modelPick(req, exp_ptr);
        gmask     = '0;
        gmask[g]  = 1'b1;
        exp_key   = i_key[128*g +: 128];
        exp_nonce = i_nonce[128*g +: 128];
        #1;
        checkOutput("idle_grant", o_grant, '0);
        tick();
        checkOutput("start_grant", o_grant, gmask);
        checkOutput("start_pulse", o_eng_start, 1);
        checkOutput("start_busy", o_busy, 1);
        checkOutput("start_key", o_eng_key, exp_key);
        checkOutput("start_nonce", o_eng_nonce, exp_nonce);
        for (int r = 0; r < N; r++) begin
            i_key[128*r +: 128]   = rand128();
            i_nonce[128*r +: 128] = rand128();
        end
        if (drop_req) i_req = '0;
        tick();
        for (int c = 0; c < TO; c++) begin
            if (c == stall_at) begin
                i_sys_enable = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    applyStimulus(fixed_pattern);
                    i_eng_done = 1'b1;
                    tick();
                    checkOutput("stall_grant", o_grant, gmask);
                    checkOutput("stall_done", o_done, '0);
                    checkOutput("stall_timeout", o_timeout, '0);
                    checkOutput("stall_tag", o_tag, exp_tag);
                end
                i_eng_done   = 1'b0;
                i_sys_enable = 1'b1;
            end
            applyStimulus(fixed_pattern);
            exp_data = i_data[64*g +: 64];
            checkOutput("run_grant", o_grant, gmask);
            checkOutput("run_start", o_eng_start, 0);
            checkOutput("run_data", o_eng_data, exp_data);
            checkOutput("run_data_valid", o_eng_data_valid, i_data_valid[g]);
            checkOutput("run_valid_cipher", o_valid_cipher, i_eng_valid_cipher ? gmask : '0);
            checkOutput("run_cipher", o_cipher, i_eng_cipher);
            checkOutput("run_done", o_done, '0);
            checkOutput("run_timeout", o_timeout, '0);
            checkOutput("run_tag", o_tag, exp_tag);
            checkOutput("run_key", o_eng_key, exp_key);
            checkOutput("run_eng_reset_n", o_eng_reset_n, 1);
            if (c == done_at) begin
                i_eng_done = 1'b1;
                exp_tag    = i_eng_tag;
            end
            tick();
            i_eng_done = 1'b0;
            if (c == done_at) break;
        end
        if (done_at < TO) begin
            checkOutput("done_pulse", o_done, gmask);
            checkOutput("done_timeout", o_timeout, '0);
            checkOutput("done_eng_reset_n", o_eng_reset_n, 1);
        end else begin
            checkOutput("flush_timeout", o_timeout, gmask);
            checkOutput("flush_done", o_done, '0);
            checkOutput("flush_eng_reset_n", o_eng_reset_n, 0);
        end
        checkOutput("end_tag", o_tag, exp_tag);
        checkOutput("end_busy", o_busy, 1);
        exp_ptr = (g + 1) % N;
        tick();
        checkOutput("idle_busy", o_busy, 0);
        checkOutput("idle_grant_clr", o_grant, '0);
        checkOutput("idle_done", o_done, '0);
        checkOutput("idle_timeout", o_timeout, '0);
        checkOutput("idle_eng_reset_n", o_eng_reset_n, 1);
        i_req = '0;
    endtask

    // Engine done/valid while idle must not create a job or touch the tag.
    task automatic idleIgnore();
        i_req              = '0;
        i_eng_done         = 1'b1;
        i_eng_valid_cipher = 1'b1;
        i_eng_tag          = rand128();
        #1;
        checkOutput("idle_valid_cipher", o_valid_cipher, '0);
        tick();
        checkOutput("idle_ign_busy", o_busy, 0);
        checkOutput("idle_ign_done", o_done, '0);
        checkOutput("idle_ign_tag", o_tag, exp_tag);
        i_eng_done         = 1'b0;
        i_eng_valid_cipher = 1'b0;
    endtask

    // Pending request with enable low must not be granted.
    task automatic idleStall();
        i_sys_enable = 1'b0;
        i_req        = '1;
        for (int s = 0; s < 3; s++) begin
            tick();
            checkOutput("idle_stall_busy", o_busy, 0);
            checkOutput("idle_stall_grant", o_grant, '0);
        end
        i_sys_enable = 1'b1;
        i_req        = '0;
        tick();
    endtask

    // Reset in the middle of a job: abort with no done or timeout.
    task automatic resetMidRun();
        int           g;
        logic [N-1:0] gmask;
        i_req    = '1;
        g        = modelPick('1, exp_ptr);
        gmask    = '0;
        gmask[g] = 1'b1;
        tick();
        checkOutput("rst_start_grant", o_grant, gmask);
        tick();
        tick();
        applyStimulus(1'b0);
        checkOutput("rst_run_busy", o_busy, 1);
        reset      = 1'b1;
        i_eng_done = 1'b1;
        #1;
        checkOutput("rst_eng_reset_n", o_eng_reset_n, 0);
        tick();
        reset      = 1'b0;
        i_eng_done = 1'b0;
        i_req      = '0;
        #1;
        exp_ptr = 0;
        exp_tag = '0;
        checkOutput("rst_grant", o_grant, '0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_done", o_done, '0);
        checkOutput("rst_timeout", o_timeout, '0);
        checkOutput("rst_tag", o_tag, '0);
        checkOutput("rst_key", o_eng_key, '0);
        checkOutput("rst_nonce", o_eng_nonce, '0);
        checkOutput("rst_start", o_eng_start, 0);
        checkOutput("rst_valid_cipher", o_valid_cipher, '0);
        checkOutput("rst_data_valid", o_eng_data_valid, 0);
        checkOutput("rst_data", o_eng_data, '0);
        checkOutput("rst_eng_reset_n_after", o_eng_reset_n, 1);
        tick();
        checkOutput("rst_no_done", o_done, '0);
        checkOutput("rst_still_idle", o_busy, 0);
    endtask

    initial begin
        logic [N-1:0] rreq;
        int           rdone;
        int           rstall;
        reset              = 1'b1;
        i_sys_enable       = 1'b1;
        i_req              = '0;
        i_key              = '0;
        i_nonce            = '0;
        i_data             = '0;
        i_data_valid       = '0;
        i_eng_cipher       = '0;
        i_eng_valid_cipher = 1'b0;
        i_eng_tag          = '0;
        i_eng_done         = 1'b0;
        exp_ptr            = 0;
        exp_tag            = '0;
        $display("[TB] ascon_arbiter bench, NUM_REQ=%0d TIMEOUT_CYCLES=%0d", N, TO);
        #1;
        checkOutput("por_eng_reset_n", o_eng_reset_n, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("reset_grant", o_grant, '0);
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_tag", o_tag, '0);
        checkOutput("reset_key", o_eng_key, '0);
        checkOutput("reset_nonce", o_eng_nonce, '0);
        checkOutput("reset_done", o_done, '0);
        checkOutput("reset_timeout", o_timeout, '0);
        checkOutput("reset_start", o_eng_start, 0);
        checkOutput("reset_eng_reset_n", o_eng_reset_n, 1);

        // Single requester with fixed key/nonce; done kept inside the watchdog window.
        runJob(3'b001, 12, -1, 1'b0, 1'b0, 1'b1);
        // Two requesters held for four jobs: alternating grants.
        for (int j = 0; j < 4; j++) runJob(3'b011, 3 + j, -1, 1'b0, 1'b0, 1'b0);
        // Requester 1 owns the engine while requester 0 drives data.
        runJob(3'b010, 8, -1, 1'b1, 1'b0, 1'b0);
        // Watchdog expiry, then the pointer moves past the timed-out owner.
        runJob(3'b001, TO + 10, -1, 1'b0, 1'b0, 1'b0);
        runJob(3'b111, 5, -1, 1'b0, 1'b0, 1'b0);
        // Done on the expiry cycle wins.
        runJob(3'b001, TO - 1, -1, 1'b0, 1'b0, 1'b0);
        // Stall mid-RUN freezes the watchdog.
        runJob(3'b100, 13, 6, 1'b0, 1'b0, 1'b0);
        // Owner withdraws its request while granted.
        runJob(3'b110, TO + 3, -1, 1'b0, 1'b1, 1'b0);
        idleIgnore();
        idleStall();
        for (int j = 0; j < 10; j++) begin
            rreq   = N'($urandom_range(1, (1 << N) - 1));
            rdone  = $urandom_range(0, 20);
            rstall = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 10) : -1;
            runJob(rreq, rdone, rstall, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        resetMidRun();
        runJob(3'b101, 4, -1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
